cabac_cu_debinari_intra: RTL and testbench

- Decoder-side counterpart of the intra CU binarizer.
- Requests bins one at a time from the CABAC bin decoder, each request carrying a regular or bypass context descriptor.
- Parses part_mode, prev_intra_luma_pred_flag, mpm_idx / rem_intra_luma_pred_mode and intra_chroma_pred_mode.
- Rebuilds the CU's packed luma modes, chroma mode and sub-division flag using the same packing the encoder-side binarizer consumes.

---
 rtl/cabac_cu_debinari_intra.sv | 295 +++++++++++++++++++++++++++++
 tb/tb_cabac_cu_debinari_intra.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cabac_cu_debinari_intra.sv
// Intra CU de-binarizer: pulls bins from the CABAC bin decoder and
// rebuilds part mode, packed luma modes and chroma mode of one CU.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start_i           one-cycle start; samples cu_depth_i, left/top modes
//   cu_depth_i        0:64x64 .. 3:8x8
//   left_mode_i       [17:12] left of PU0, [5:0] left of PU2
//   top_mode_i        [11:6] top of PU0, [5:0] top of PU1
//   bin_req_o         bin request, held until bin_vld_i
//   bin_bypass_o      1 = bypass bin
//   bin_bank_o/addr_o context descriptor (0 for bypass)
//   bin_vld_i, bin_i  bin delivery
//   busy_o, done_o    parse in progress / one-cycle completion pulse
//   cu_sub_div_o      1 = NxN
//   luma_mode_o       PU0 [23:18] .. PU3 [5:0]
//   chroma_mode_o     36 = DM, else explicit mode
module cabac_cu_debinari_intra #(
    parameter logic [2:0] PART_BANK   = 3'd3,
    parameter logic [4:0] PART_ADDR   = 5'd26,
    parameter logic [2:0] LUMA_BANK   = 3'd2,
    parameter logic [4:0] LUMA_ADDR   = 5'd28,
    parameter logic [2:0] CHROMA_BANK = 3'd1,
    parameter logic [4:0] CHROMA_ADDR = 5'd30
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [1:0]  cu_depth_i,
    input  logic [23:0] left_mode_i,
    input  logic [23:0] top_mode_i,
    output logic        bin_req_o,
    output logic        bin_bypass_o,
    output logic [2:0]  bin_bank_o,
    output logic [4:0]  bin_addr_o,
    input  logic        bin_vld_i,
    input  logic        bin_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        cu_sub_div_o,
    output logic [23:0] luma_mode_o,
    output logic [5:0]  chroma_mode_o
);

    localparam logic [8:0] D_PART = {1'b0, PART_BANK, PART_ADDR};
    localparam logic [8:0] D_LUMA = {1'b0, LUMA_BANK, LUMA_ADDR};
    localparam logic [8:0] D_CHR  = {1'b0, CHROMA_BANK, CHROMA_ADDR};
    localparam logic [8:0] D_BYP  = 9'h100;
    localparam logic [8:0] D_NONE = 9'h000;

    typedef enum logic [2:0] {
        S_IDLE, S_PART, S_PREV, S_IDX,
        S_DERIVE, S_CHR_R, S_CHR_B, S_DONE
    } state_t;

    state_t          state_q;
    logic            req_q;
    logic [8:0]      desc_q;
    logic            busy_q;
    logic            done_q;
    logic            sub_o_q;
    logic [23:0]     luma_q;
    logic [5:0]      chroma_q;
    logic            sub_q;
    logic [3:0]      flag_q;
    logic [1:0]      pu_q;
    logic [2:0]      cnt_q;
    logic [4:0]      val_q;
    logic [11:0]     left_q;
    logic [11:0]     top_q;
    // index 0 is PU0, which lands in the MSB field of the packed vector
    logic [0:3][5:0] work_q;

    logic       fire;
    logic       idx_last;
    logic [1:0] last_pu;
    logic [5:0] nb_a, nb_b;
    logic [5:0] m0, m1, m2;
    logic [5:0] s0, s1, s2, tmp;
    logic [5:0] mpm_mode, rem_mode, der_mode;
    logic [1:0] chr_idx;
    logic [5:0] chr_base, chr_mode;
    logic       unused_ok;

    assign unused_ok = ^{left_mode_i[23:18], left_mode_i[11:6],
                         top_mode_i[23:12]};

    assign fire     = req_q & bin_vld_i;
    assign last_pu  = sub_q ? 2'd3 : 2'd0;
    // mpm_idx ends on a 0 bin or after its second bin; rem after 5 bins
    assign idx_last = flag_q[pu_q] ? ((cnt_q != 3'd0) | ~bin_i)
                                   : (cnt_q == 3'd4);

    always_comb begin
        nb_a = '0;
        nb_b = '0;
        case (pu_q)
            2'd0: begin nb_a = left_q[11:6]; nb_b = top_q[11:6]; end
            2'd1: begin nb_a = work_q[0];    nb_b = top_q[5:0];  end
            2'd2: begin nb_a = left_q[5:0];  nb_b = work_q[0];   end
            default: begin nb_a = work_q[2]; nb_b = work_q[1];   end
        endcase

        if (nb_a == nb_b) begin
            if (nb_a < 6'd2) begin
                m0 = 6'd0;
                m1 = 6'd1;
                m2 = 6'd26;
            end else begin
                m0 = nb_a;
                m1 = 6'd2 + ((nb_a + 6'd29) & 6'd31);
                m2 = 6'd2 + ((nb_a - 6'd1) & 6'd31);
            end
        end else begin
            m0 = nb_a;
            m1 = nb_b;
            if (nb_a != 6'd0 && nb_b != 6'd0)      m2 = 6'd0;
            else if (nb_a != 6'd1 && nb_b != 6'd1) m2 = 6'd1;
            else                                   m2 = 6'd26;
        end

        case (val_q[1:0])
            2'd0:    mpm_mode = m0;
            2'd1:    mpm_mode = m1;
            default: mpm_mode = m2;
        endcase

        // three-element sorting network
        s0 = m0;
        s1 = m1;
        s2 = m2;
        if (s0 > s1) begin tmp = s0; s0 = s1; s1 = tmp; end
        else tmp = s0;
        if (s1 > s2) begin tmp = s1; s1 = s2; s2 = tmp; end
        if (s0 > s1) begin tmp = s0; s0 = s1; s1 = tmp; end

        rem_mode = {1'b0, val_q};
        if (rem_mode >= s0) rem_mode = rem_mode + 6'd1;
        if (rem_mode >= s1) rem_mode = rem_mode + 6'd1;
        if (rem_mode >= s2) rem_mode = rem_mode + 6'd1;

        der_mode = flag_q[pu_q] ? mpm_mode : rem_mode;

        chr_idx = {val_q[0], bin_i};
        case (chr_idx)
            2'd0:    chr_base = 6'd0;
            2'd1:    chr_base = 6'd26;
            2'd2:    chr_base = 6'd10;
            default: chr_base = 6'd1;
        endcase
        chr_mode = (chr_base == work_q[3]) ? 6'd34 : chr_base;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            req_q    <= 1'b0;
            desc_q   <= D_NONE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            sub_o_q  <= 1'b0;
            luma_q   <= '0;
            chroma_q <= '0;
            sub_q    <= 1'b0;
            flag_q   <= '0;
            pu_q     <= '0;
            cnt_q    <= '0;
            val_q    <= '0;
            left_q   <= '0;
            top_q    <= '0;
            work_q   <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        left_q <= {left_mode_i[17:12], left_mode_i[5:0]};
                        top_q  <= top_mode_i[11:0];
                        busy_q <= 1'b1;
                        flag_q <= '0;
                        pu_q   <= '0;
                        cnt_q  <= '0;
                        val_q  <= '0;
                        sub_q  <= 1'b0;
                        req_q  <= 1'b1;
                        if (cu_depth_i == 2'd3) begin
                            desc_q  <= D_PART;
                            state_q <= S_PART;
                        end else begin
                            desc_q  <= D_LUMA;
                            state_q <= S_PREV;
                        end
                    end
                end
                S_PART: begin
                    if (fire) begin
                        sub_q   <= ~bin_i;
                        desc_q  <= D_LUMA;
                        state_q <= S_PREV;
                    end
                end
                S_PREV: begin
                    if (fire) begin
                        flag_q[cnt_q[1:0]] <= bin_i;
                        if (cnt_q[1:0] == last_pu) begin
                            cnt_q   <= '0;
                            val_q   <= '0;
                            desc_q  <= D_BYP;
                            state_q <= S_IDX;
                        end else begin
                            cnt_q <= cnt_q + 3'd1;
                        end
                    end
                end
                S_IDX: begin
                    if (fire) begin
                        if (flag_q[pu_q])
                            val_q <= (cnt_q == 3'd0) ? {4'd0, bin_i}
                                   : (bin_i ? 5'd2 : 5'd1);
                        else
                            val_q <= {val_q[3:0], bin_i};
                        cnt_q <= cnt_q + 3'd1;
                        if (idx_last) begin
                            req_q   <= 1'b0;
                            desc_q  <= D_NONE;
                            state_q <= S_DERIVE;
                        end
                    end
                end
                S_DERIVE: begin
                    if (sub_q) work_q[pu_q] <= der_mode;
                    else       work_q <= {4{der_mode}};
                    req_q <= 1'b1;
                    cnt_q <= '0;
                    val_q <= '0;
                    if (pu_q != last_pu) begin
                        pu_q    <= pu_q + 2'd1;
                        desc_q  <= D_BYP;
                        state_q <= S_IDX;
                    end else begin
                        desc_q  <= D_CHR;
                        state_q <= S_CHR_R;
                    end
                end
                S_CHR_R: begin
                    if (fire) begin
                        if (!bin_i) begin
                            req_q    <= 1'b0;
                            desc_q   <= D_NONE;
                            luma_q   <= work_q;
                            chroma_q <= 6'd36;
                            sub_o_q  <= sub_q;
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
                            state_q  <= S_DONE;
                        end else begin
                            desc_q  <= D_BYP;
                            state_q <= S_CHR_B;
                        end
                    end
                end
                S_CHR_B: begin
                    if (fire) begin
                        val_q <= {val_q[3:0], bin_i};
                        cnt_q <= cnt_q + 3'd1;
                        if (cnt_q != 3'd0) begin
                            req_q    <= 1'b0;
                            desc_q   <= D_NONE;
                            luma_q   <= work_q;
                            chroma_q <= chr_mode;
                            sub_o_q  <= sub_q;
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
                            state_q  <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bin_req_o     = req_q;
    assign bin_bypass_o  = desc_q[8];
    assign bin_bank_o    = desc_q[7:5];
    assign bin_addr_o    = desc_q[4:0];
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign cu_sub_div_o  = sub_o_q;
    assign luma_mode_o   = luma_q;
    assign chroma_mode_o = chroma_q;

endmodule

// File: tb/tb_cabac_cu_debinari_intra.sv
// Bench for cabac_cu_debinari_intra: acts as the bin decoder, predicts
// the descriptor stream and final modes from a reference parse model.
module tb_cabac_cu_debinari_intra;

    localparam logic [8:0] DP = {1'b0, 3'd3, 5'd26};
    localparam logic [8:0] DL = {1'b0, 3'd2, 5'd28};
    localparam logic [8:0] DC = {1'b0, 3'd1, 5'd30};
    localparam logic [8:0] DB = 9'h100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0;
    logic [1:0]  cu_depth_i = '0;
    logic [23:0] left_mode_i = '0;
    logic [23:0] top_mode_i = '0;
    logic        bin_vld_i = 1'b0;
    logic        bin_i = 1'b0;
    logic        bin_req_o, bin_bypass_o;
    logic [2:0]  bin_bank_o;
    logic [4:0]  bin_addr_o;
    logic        busy_o, done_o, cu_sub_div_o;
    logic [23:0] luma_mode_o;
    logic [5:0]  chroma_mode_o;

    cabac_cu_debinari_intra dut (
        .clk(clk), .rst(rst), .start_i(start_i),
        .cu_depth_i(cu_depth_i),
        .left_mode_i(left_mode_i), .top_mode_i(top_mode_i),
        .bin_req_o(bin_req_o), .bin_bypass_o(bin_bypass_o),
        .bin_bank_o(bin_bank_o), .bin_addr_o(bin_addr_o),
        .bin_vld_i(bin_vld_i), .bin_i(bin_i),
        .busy_o(busy_o), .done_o(done_o),
        .cu_sub_div_o(cu_sub_div_o),
        .luma_mode_o(luma_mode_o), .chroma_mode_o(chroma_mode_o)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    logic        bq[$];
    logic [8:0]  dq[$];
    int          bidx = 0;
    bit          armed = 0;
    bit          seen_done = 0;
    bit          stray = 0;
    bit          held = 0;
    int          stall_cnt = 0;
    logic [23:0] e_luma = '0;
    logic [5:0]  e_chroma = '0;
    logic        e_sub = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    function automatic int mpm_at(int a, int b, int i);
        int c;
        if (a == b) begin
            if (a < 2) return (i == 0) ? 0 : (i == 1) ? 1 : 26;
            return (i == 0) ? a : (i == 1) ? 2 + ((a + 29) % 32)
                                           : 2 + ((a + 31) % 32);
        end
        if (a != 0 && b != 0)      c = 0;
        else if (a != 1 && b != 1) c = 1;
        else                       c = 26;
        return (i == 0) ? a : (i == 1) ? b : c;
    endfunction

    // rem selects the rem-th mode (counting from 0) that is not an MPM
    function automatic int rem_to_mode(int a, int b, int r);
        int n = r;
        for (int v = 0; v < 64; v++) begin
            if (v != mpm_at(a, b, 0) && v != mpm_at(a, b, 1) &&
                v != mpm_at(a, b, 2)) begin
                if (n == 0) return v;
                n--;
            end
        end
        return -1;
    endfunction

    function automatic void build_model(input logic [1:0] d,
                                        input logic [23:0] l,
                                        input logic [23:0] t);
        int m[4];
        bit fl[4];
        int p, n, a, b, v, idx, base;
        bit sub;
        dq.delete();
        p = 0;
        sub = 0;
        a = 0;
        b = 0;
        if (d == 2'd3) begin
            dq.push_back(DP);
            sub = (bq[p] == 1'b0);
            p++;
        end
        n = sub ? 4 : 1;
        for (int k = 0; k < n; k++) begin
            dq.push_back(DL);
            fl[k] = bq[p];
            p++;
        end
        for (int k = 0; k < n; k++) begin
            case (k)
                0: begin a = int'(l[17:12]); b = int'(t[11:6]); end
                1: begin a = m[0]; b = int'(t[5:0]); end
                2: begin a = int'(l[5:0]); b = m[0]; end
                default: begin a = m[2]; b = m[1]; end
            endcase
            if (fl[k]) begin
                dq.push_back(DB);
                if (bq[p] == 1'b0) begin
                    idx = 0;
                    p++;
                end else begin
                    p++;
                    dq.push_back(DB);
                    idx = 1 + int'(bq[p]);
                    p++;
                end
                m[k] = mpm_at(a, b, idx);
            end else begin
                v = 0;
                for (int j = 0; j < 5; j++) begin
                    dq.push_back(DB);
                    v = v * 2 + int'(bq[p]);
                    p++;
                end
                m[k] = rem_to_mode(a, b, v);
            end
        end
        if (!sub) begin
            m[1] = m[0];
            m[2] = m[0];
            m[3] = m[0];
        end
        e_luma = {6'(m[0]), 6'(m[1]), 6'(m[2]), 6'(m[3])};
        dq.push_back(DC);
        if (bq[p] == 1'b0) begin
            e_chroma = 6'd36;
        end else begin
            dq.push_back(DB);
            dq.push_back(DB);
            idx = 2 * int'(bq[p + 1]) + int'(bq[p + 2]);
            base = (idx == 0) ? 0 : (idx == 1) ? 26 : (idx == 2) ? 10 : 1;
            e_chroma = 6'((base == m[3]) ? 34 : base);
        end
        e_sub = sub;
    endfunction

    function automatic logic [23:0] lv(logic [5:0] pu0, logic [5:0] pu2);
        return {6'd63, pu0, 6'd63, pu2};
    endfunction

    function automatic logic [23:0] tv(logic [5:0] pu0, logic [5:0] pu1);
        return {12'hfff, pu0, pu1};
    endfunction

    // bin source plus per-cycle output compare
    always @(negedge clk) begin
        if (armed && !rst) begin
            if (held) begin
                chk("stall_hold", bin_req_o, 1);
                held = 0;
            end
            if (bin_req_o) begin
                if (bidx < dq.size())
                    chk("desc", {bin_bypass_o, bin_bank_o, bin_addr_o},
                        dq[bidx]);
                else
                    chk("extra_req", bin_req_o, 0);
            end
            if (done_o) begin
                chk("luma", luma_mode_o, e_luma);
                chk("chroma", chroma_mode_o, e_chroma);
                chk("sub_div", cu_sub_div_o, e_sub);
                chk("nbins", bidx, dq.size());
                seen_done = 1;
            end
        end
        if (bin_req_o && stall_cnt > 0) begin
            stall_cnt--;
            bin_vld_i = 1'b0;
            held = armed;
        end else if (bin_req_o && bidx < bq.size()) begin
            bin_vld_i = 1'b1;
            bin_i = bq[bidx];
            bidx++;
        end else begin
            bin_vld_i = stray;
            bin_i = 1'b1;
        end
    end

    task automatic start_cu(input logic [1:0] d, input logic [23:0] l,
                            input logic [23:0] t);
        build_model(d, l, t);
        bidx = 0;
        seen_done = 0;
        held = 0;
        @(negedge clk);
        armed = 1;
        cu_depth_i = d;
        left_mode_i = l;
        top_mode_i = t;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        chk("busy_after_start", busy_o, 1);
    endtask

    task automatic wait_done(input int glitch);
        bit g = 0;
        for (int c = 0; c < 400 && !seen_done; c++) begin
            @(negedge clk);
            if (start_i) begin
                start_i = 1'b0;
            end else if (!g && glitch >= 0 && bidx >= glitch) begin
                g = 1;
                start_i = 1'b1;
                cu_depth_i = 2'd3;
                left_mode_i = '1;
            end
        end
        start_i = 1'b0;
        chk("timeout", seen_done, 1);
        @(negedge clk);
        chk("done_pulse", done_o, 0);
        chk("hold_luma", luma_mode_o, e_luma);
        armed = 0;
    endtask

    task automatic run_cu(input logic [1:0] d, input logic [23:0] l,
                          input logic [23:0] t, input int glitch);
        start_cu(d, l, t);
        wait_done(glitch);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_req", bin_req_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_luma", luma_mode_o, 0);
        chk("rst_chroma", chroma_mode_o, 0);
        chk("rst_sub", cu_sub_div_o, 0);
        rst = 1'b0;

        // single PU, mpm_idx 0, DM chroma
        bq = '{1'b1, 1'b0, 1'b0};
        run_cu(2'd0, lv(6'd10, 6'd0), tv(6'd10, 6'd0), -1);
        chk("t1_luma", luma_mode_o, {4{6'd10}});
        chk("t1_chroma", chroma_mode_o, 36);
        chk("t1_model", e_luma, {4{6'd10}});

        // depth 3 with 2Nx2N part, mpm_idx 1, chroma idx 2
        bq = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        run_cu(2'd3, lv(6'd10, 6'd0), tv(6'd10, 6'd0), -1);
        chk("t2_luma", luma_mode_o, {4{6'd9}});
        chk("t2_chroma", chroma_mode_o, 10);
        chk("t2_sub", cu_sub_div_o, 0);

        // NxN: rem, mpm1, mpm2, rem -> 5, 4, 0, 13
        bq = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0,
               1'b0, 1'b0, 1'b0, 1'b1, 1'b1,
               1'b1, 1'b0, 1'b1, 1'b1,
               1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        run_cu(2'd3, lv(6'd0, 6'd3), tv(6'd1, 6'd5), -1);
        chk("t3_luma", luma_mode_o, {6'd5, 6'd4, 6'd0, 6'd13});
        chk("t3_sub", cu_sub_div_o, 1);
        chk("t3_model", e_luma, {6'd5, 6'd4, 6'd0, 6'd13});

        // chroma substitution with L=26
        bq = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        run_cu(2'd0, lv(6'd26, 6'd0), tv(6'd26, 6'd0), -1);
        chk("t4a_chroma", chroma_mode_o, 34);

        // no substitution with L=7; stray start mid-parse
        bq = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        run_cu(2'd0, lv(6'd7, 6'd0), tv(6'd7, 6'd0), 2);
        chk("t4b_chroma", chroma_mode_o, 26);
        chk("t4b_luma", luma_mode_o, {4{6'd7}});

        // stalled first bin and stray bin_vld_i while idle of request
        bq = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0,
               1'b0, 1'b0, 1'b0, 1'b1, 1'b1,
               1'b1, 1'b0, 1'b1, 1'b1,
               1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        stall_cnt = 5;
        stray = 1;
        run_cu(2'd3, lv(6'd0, 6'd3), tv(6'd1, 6'd5), -1);
        stray = 0;
        stall_cnt = 0;
        chk("t5_luma", luma_mode_o, {6'd5, 6'd4, 6'd0, 6'd13});

        // reset in the middle of the IDX phase
        start_cu(2'd3, lv(6'd0, 6'd3), tv(6'd1, 6'd5));
        for (int c = 0; c < 100 && bidx < 8; c++) @(negedge clk);
        chk("abort_reach", bidx >= 8, 1);
        armed = 0;
        bq.delete();
        rst = 1'b1;
        @(negedge clk);
        chk("abort_req", bin_req_o, 0);
        chk("abort_busy", busy_o, 0);
        chk("abort_luma", luma_mode_o, 0);
        chk("abort_chroma", chroma_mode_o, 0);
        chk("abort_done", done_o, 0);
        rst = 1'b0;

        bq = '{1'b1, 1'b0, 1'b0};
        run_cu(2'd0, lv(6'd10, 6'd0), tv(6'd10, 6'd0), -1);
        chk("t6_luma", luma_mode_o, {4{6'd10}});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
